if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180, fetch address after a misaligned redirect (REQ-030).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  downstream hazard; IF/ID register cannot accept this cycle.
REQ-006 redirect  in  1  taken branch/jump from ID.
REQ-007 redirect_pc  in  32  redirect target.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address.
REQ-010 imem_ready  in  1  response valid this cycle; completes the current request.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ready.
REQ-012 out_valid  out  1  out_pc4/out_instr hold a real instruction; low drives the IF/ID hazard (bubble).
REQ-013 out_pc4  out  32  fetch address + 4.
REQ-014 out_instr  out  32  fetched instruction.
REQ-015 out_exc  out  1  misaligned-fetch exception marker travelling with out_valid.

Function
REQ-016 States: IDLE, FETCH, HOLD, DRAIN; registers pc (next fetch address), req_addr (outstanding address), output buffer {out_pc4, out_instr, out_exc}.
REQ-017 IDLE: imem_req=0; next cycle -> FETCH with req_addr=pc.
REQ-018 FETCH: imem_req=1, imem_addr=req_addr held stable until imem_ready.
REQ-019 FETCH & imem_ready & !redirect: buffer <= {req_addr+4, imem_rdata, 0}; pc <= req_addr+4; -> HOLD; out_valid rises next cycle (1-cycle latency).
REQ-020 HOLD: out_valid=1, buffer constant while stall=1.
REQ-021 HOLD & !stall & !redirect: imem_req=1 at imem_addr=pc (back-to-back); on same-cycle imem_ready buffer reloads, stay HOLD; else -> FETCH, out_valid=0.
REQ-022 redirect has priority over stall and imem_ready in every state; buffer dropped, out_valid=0 next cycle, pc <= redirect_pc.
REQ-023 redirect in FETCH without imem_ready -> DRAIN; in FETCH with imem_ready or in HOLD/IDLE -> FETCH at redirect_pc.
REQ-024 DRAIN: imem_req=1 at old req_addr; imem_ready response discarded; then -> FETCH at pc; a second redirect in DRAIN only updates pc.
REQ-025 Address arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-026 No instruction is emitted twice or skipped absent redirect.

Reset
REQ-027 rst=0 at a rising edge: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, out_valid=0, out_pc4=0, out_instr=0, out_exc=0, imem_req=0, regardless of state.
REQ-028 Reset mid-request abandons it; a late imem_ready is ignored in IDLE.

Configuration
REQ-029 Macro IF_STAGE_ALIGN_EN selects misaligned-redirect checking.
REQ-030 Defined: redirect_pc[1:0]!=0 -> no fetch of target; next cycle out_valid=1, out_exc=1, out_instr=32'h0, out_pc4=redirect_pc+4 (held under stall); then fetch at EXC_VEC.
REQ-031 Undefined: redirect_pc[1:0] forced to 2'b00; out_exc tied 0.

Structure
REQ-032 Package pipeline_pkg: RESET_PC/EXC_VEC defaults, NOP word 32'h0, if_state_t enum.
REQ-033 Sub-module if_fetch_buf: output buffer with load/hold/clear; FSM and pc in if_stage.

Verification
REQ-034 Reset release, imem_ready=1 every cycle, stall=0 -> imem_addr 3000,3004,3008; out_pc4 3004,3008,300C, one per cycle from cycle 2.
REQ-035 stall=1 for 3 cycles while HOLD -> out_instr/out_pc4 constant, imem_req=0, no address skipped after release.
REQ-036 redirect=1, redirect_pc=3100, same cycle as imem_ready -> that word dropped, next imem_addr=3100, one bubble (out_valid=0).
REQ-037 imem_ready 3-cycle latency, redirect to 3200 in its first cycle -> DRAIN holds old addr, response discarded, then imem_addr=3200.
REQ-038 IF_STAGE_ALIGN_EN, redirect_pc=3202 -> out_exc=1, out_instr=0, out_pc4=3206, then imem_addr=4180; without macro imem_addr=3200, out_exc=0.
REQ-039 rst=0 while HOLD with stall=1 -> next cycle out_valid=0, imem_req=0, then imem_addr=3000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: reset/exception vectors, NOP word,
// fetch FSM state encoding and the IF/ID buffer entry.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_FETCH,
        IF_HOLD,
        IF_DRAIN
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        exc;
    } fetch_ent_t;

endpackage

// File: rtl/if_fetch_buf.sv
// IF/ID output buffer: load wins over clear, otherwise the entry holds.
module if_fetch_buf
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  fetch_ent_t ld_ent,
    output logic       valid,
    output fetch_ent_t ent
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            ent   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ent   <= ld_ent;
        end else if (clear) begin
            valid <= 1'b0;
            ent   <= '0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pc/request FSM driving imem and the IF/ID buffer.
// Define IF_STAGE_ALIGN_EN to turn misaligned redirect targets into fetch exceptions.
module if_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc4,
    output logic [31:0] out_instr,
    output logic        out_exc
);

    if_state_t   state;
    logic [31:0] pc, req_addr;
    logic [31:0] tgt, resume_pc;
    logic        tgt_misal, pc_misal, resume_misal, resume;
    logic        buf_load, buf_clear, buf_valid;
    fetch_ent_t  ld_ent, buf_ent;

`ifdef IF_STAGE_ALIGN_EN
    assign tgt       = redirect_pc;
    assign tgt_misal = |redirect_pc[1:0];
    assign pc_misal  = |pc[1:0];
`else
    assign tgt       = redirect_pc & ~32'h3;
    assign tgt_misal = 1'b0;
    assign pc_misal  = 1'b0;
`endif

    // Where fetching restarts once no request is outstanding; a redirect seen
    // in the same cycle overrides the pc parked by an earlier one.
    assign resume_pc    = redirect ? tgt : pc;
    assign resume_misal = redirect ? tgt_misal : pc_misal;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = req_addr;
        resume    = 1'b0;
        buf_load  = 1'b0;
        buf_clear = redirect;
        ld_ent    = '{pc4: req_addr + 32'd4, instr: imem_rdata, exc: 1'b0};
        case (state)
            IF_IDLE: resume = redirect;
            IF_FETCH: begin
                imem_req = 1'b1;
                if (redirect) resume   = imem_ready;
                else          buf_load = imem_ready;
            end
            IF_HOLD: begin
                if (redirect) begin
                    resume = 1'b1;
                end else if (!stall) begin
                    // buffer is taken this cycle; issue the next fetch back-to-back
                    imem_req   = 1'b1;
                    imem_addr  = pc;
                    buf_clear  = 1'b1;
                    buf_load   = imem_ready;
                    ld_ent.pc4 = pc + 32'd4;
                end
            end
            IF_DRAIN: begin
                imem_req = 1'b1;
                resume   = imem_ready;
            end
        endcase
        if (resume && resume_misal) begin
            buf_load = 1'b1;
            ld_ent   = '{pc4: resume_pc + 32'd4, instr: NOP_WORD, exc: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IF_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else if (resume) begin
            if (resume_misal) begin
                state <= IF_HOLD;
                pc    <= EXC_VEC;
            end else begin
                state    <= IF_FETCH;
                pc       <= resume_pc;
                req_addr <= resume_pc;
            end
        end else begin
            case (state)
                IF_IDLE: begin
                    state    <= IF_FETCH;
                    req_addr <= pc;
                end
                IF_FETCH: begin
                    if (redirect) begin
                        state <= IF_DRAIN;
                        pc    <= tgt;
                    end else if (imem_ready) begin
                        state <= IF_HOLD;
                        pc    <= req_addr + 32'd4;
                    end
                end
                IF_HOLD: begin
                    if (!stall) begin
                        req_addr <= pc;
                        if (imem_ready) pc    <= pc + 32'd4;
                        else            state <= IF_FETCH;
                    end
                end
                IF_DRAIN: begin
                    if (redirect) pc <= tgt;
                end
            endcase
        end
    end

    if_fetch_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .clear  (buf_clear),
        .ld_ent (ld_ent),
        .valid  (buf_valid),
        .ent    (buf_ent)
    );

    assign out_valid = buf_valid;
    assign out_pc4   = buf_ent.pc4;
    assign out_instr = buf_ent.instr;
    assign out_exc   = buf_ent.exc;

endmodule
